// File: rtl/sp_pkg.sv
// Shared definitions for the single-cycle-core instruction feeder.
// Holds the feeder state encoding, the fault codes it reports and the
// instruction word width used by the feeder and its ROM.
package sp_pkg;

  localparam int INST_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    RUN,
    DRAIN,
    DONE,
    FAULT
  } state_t;

  localparam logic [1:0] FLT_NONE  = 2'd0;
  localparam logic [1:0] FLT_ADDR  = 2'd1;
  localparam logic [1:0] FLT_LAT   = 2'd2;
  localparam logic [1:0] FLT_PROTO = 2'd3;

endpackage

// File: rtl/sp_inst_rom.sv
// Instruction ROM for the feeder: 2**ADDR_W words of INST_W bits.
// Ports:
//   i_clk     write clock (rising edge)
//   i_we      write strobe, already qualified by the feeder state
//   i_waddr   write word index
//   i_wdata   write data
//   i_raddr   read word index
//   o_rdata   combinational read data (same-cycle fetch)
// Contents are not reset; the program survives a feeder reset.
module sp_inst_rom
  import sp_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [INST_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [INST_W-1:0] o_rdata
);

  logic [INST_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sp_inst_feeder.sv
// Instruction feeder for the single-cycle core. A program is written into
// the internal ROM while idle; a start pulse launches a run of i_exec_num
// instructions after START_DELAY idle cycles. The core's byte PC selects the
// ROM word presented on o_inst. Issued and retired instructions are counted
// and the core's retire protocol is monitored for faults.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_prog_we/addr/wdata   ROM write port (honoured in IDLE/DONE/FAULT only)
//   i_start, i_exec_num    start pulse and instruction count (sampled on start)
//   o_in_valid, o_inst     instruction handshake to the core
//   i_out_valid            core retire strobe
//   i_inst_addr            core byte PC
//   o_busy/o_done/o_fault  run status levels
//   o_fault_code           0 none, 1 bad address, 2 latency, 3 protocol
//   o_issued_cnt           cycles with o_in_valid=1 since start
//   o_retired_cnt          cycles with i_out_valid=1 since start
module sp_inst_feeder
  import sp_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int START_DELAY = 2,
  parameter int MAX_LAT     = 10,
  parameter int CNT_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [INST_W-1:0] i_prog_wdata,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_exec_num,
  output logic              o_in_valid,
  output logic [INST_W-1:0] o_inst,
  input  logic              i_out_valid,
  input  logic [31:0]       i_inst_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fault,
  output logic [1:0]        o_fault_code,
  output logic [CNT_W-1:0]  o_issued_cnt,
  output logic [CNT_W-1:0]  o_retired_cnt
);

  localparam int         LAT_W    = $clog2(MAX_LAT + 1);
  localparam logic [3:0] DLY_INIT = 4'(START_DELAY - 1);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t              r_state;
  logic                r_in_valid;
  logic [CNT_W-1:0]    r_exec_num;
  logic [CNT_W-1:0]    r_issued;
  logic [CNT_W-1:0]    r_retired;
  logic [LAT_W-1:0]    r_lat;
  logic [3:0]          r_dly;
  logic [1:0]          r_fault_code;

  logic                w_quiet;
  logic                w_rom_we;
  logic                w_bad_addr;
  logic                w_lat_tick;
  logic                w_lat_expire;
  logic                w_dropout;
  logic                w_last_issue;
  logic                w_last_retire;
  logic [INST_W-1:0]   w_rom_rdata;

  assign w_quiet  = (r_state == IDLE) || (r_state == DONE) || (r_state == FAULT);
  assign w_rom_we = i_prog_we && w_quiet;

  // Only word-aligned PCs inside the ROM are legal fetch addresses.
  assign w_bad_addr    = r_in_valid &&
                         ((i_inst_addr[1:0] != 2'b00) || (i_inst_addr[31:ADDR_W+2] != '0));
  // Latency is measured only until the first retirement.
  assign w_lat_tick    = (r_retired == '0) && !i_out_valid;
  assign w_lat_expire  = w_lat_tick && (r_lat == LAT_W'(MAX_LAT - 1));
  // Once retirement has started, out_valid must stay high until the last one.
  assign w_dropout     = (r_retired != '0) && (r_retired < r_exec_num) && !i_out_valid;
  assign w_last_issue  = r_in_valid && (sat_inc(r_issued) == r_exec_num);
  assign w_last_retire = i_out_valid && (sat_inc(r_retired) == r_exec_num);

  sp_inst_rom #(
    .ADDR_W (ADDR_W)
  ) u_rom (
    .i_clk   (i_clk),
    .i_we    (w_rom_we),
    .i_waddr (i_prog_addr),
    .i_wdata (i_prog_wdata),
    .i_raddr (i_inst_addr[ADDR_W+1:2]),
    .o_rdata (w_rom_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_in_valid   <= 1'b0;
      r_exec_num   <= '0;
      r_issued     <= '0;
      r_retired    <= '0;
      r_lat        <= '0;
      r_dly        <= '0;
      r_fault_code <= FLT_NONE;
    end else begin
      case (r_state)
        IDLE, DONE, FAULT: begin
          if (i_start) begin
            r_exec_num   <= i_exec_num;
            r_issued     <= '0;
            r_retired    <= '0;
            r_lat        <= '0;
            r_fault_code <= FLT_NONE;
            r_dly        <= DLY_INIT;
            r_state      <= (i_exec_num == '0) ? DONE : DELAY;
          end else if ((r_state == DONE) && i_out_valid) begin
            r_state      <= FAULT;
            r_fault_code <= FLT_PROTO;
          end
        end
        DELAY: begin
          if (r_dly == '0) begin
            r_state    <= RUN;
            r_in_valid <= 1'b1;
          end else begin
            r_dly <= r_dly - 1'b1;
          end
        end
        RUN, DRAIN: begin
          // Counts reflect what happened this cycle, including a faulting one.
          if (r_in_valid)  r_issued  <= sat_inc(r_issued);
          if (i_out_valid) r_retired <= sat_inc(r_retired);
          if (w_lat_tick)  r_lat     <= r_lat + 1'b1;
          if (w_bad_addr) begin
            r_state      <= FAULT;
            r_in_valid   <= 1'b0;
            r_fault_code <= FLT_ADDR;
          end else if (w_lat_expire) begin
            r_state      <= FAULT;
            r_in_valid   <= 1'b0;
            r_fault_code <= FLT_LAT;
          end else if (w_dropout) begin
            r_state      <= FAULT;
            r_in_valid   <= 1'b0;
            r_fault_code <= FLT_PROTO;
          end else if (w_last_retire) begin
            r_state    <= DONE;
            r_in_valid <= 1'b0;
          end else if (w_last_issue) begin
            r_state    <= DRAIN;
            r_in_valid <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_valid    = r_in_valid;
  assign o_inst        = r_in_valid ? w_rom_rdata : '0;
  assign o_busy        = (r_state == DELAY) || (r_state == RUN) || (r_state == DRAIN);
  assign o_done        = (r_state == DONE);
  assign o_fault       = (r_state == FAULT);
  assign o_fault_code  = r_fault_code;
  assign o_issued_cnt  = r_issued;
  assign o_retired_cnt = r_retired;

endmodule

// File: tb/tb_sp_inst_feeder.sv
// Scoreboard bench for sp_inst_feeder: the stimulus pushes the instruction
// words it expects the feeder to present; a negedge monitor pops one entry
// per in_valid cycle and also requires inst=0 whenever in_valid is low.
module tb_sp_inst_feeder;

  localparam int ADDR_W = 9;
  localparam int CNT_W  = 16;

  localparam logic [31:0] W0 = 32'h00A00093;
  localparam logic [31:0] W1 = 32'h00108113;
  localparam logic [31:0] W2 = 32'h002101B3;
  localparam logic [31:0] W3 = 32'h00318233;

  logic              clk        = 1'b0;
  logic              rst_n      = 1'b1;
  logic              prog_we    = 1'b0;
  logic [ADDR_W-1:0] prog_addr  = '0;
  logic [31:0]       prog_wdata = '0;
  logic              start      = 1'b0;
  logic [CNT_W-1:0]  exec_num   = '0;
  logic              out_valid  = 1'b0;
  logic [31:0]       inst_addr  = '0;

  logic              in_valid;
  logic [31:0]       inst;
  logic              busy;
  logic              done;
  logic              fault;
  logic [1:0]        fault_code;
  logic [CNT_W-1:0]  issued_cnt;
  logic [CNT_W-1:0]  retired_cnt;

  int          checks = 0;
  int          errors = 0;
  int          core_pc = 0;
  logic [31:0] exp_q[$];

  sp_inst_feeder #(
    .ADDR_W      (ADDR_W),
    .START_DELAY (2),
    .MAX_LAT     (10),
    .CNT_W       (CNT_W)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_prog_we     (prog_we),
    .i_prog_addr   (prog_addr),
    .i_prog_wdata  (prog_wdata),
    .i_start       (start),
    .i_exec_num    (exec_num),
    .o_in_valid    (in_valid),
    .o_inst        (inst),
    .i_out_valid   (out_valid),
    .i_inst_addr   (inst_addr),
    .o_busy        (busy),
    .o_done        (done),
    .o_fault       (fault),
    .o_fault_code  (fault_code),
    .o_issued_cnt  (issued_cnt),
    .o_retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard entry per presented instruction.
  always @(negedge clk) begin
    if (in_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got inst %h with no expected entry (t=%0t)", inst, $time);
      end else begin
        check("sb_inst", inst, exp_q.pop_front());
      end
    end else begin
      check("inst_idle_zero", inst, 32'h0);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    prog_we    = 1'b1;
    prog_addr  = a;
    prog_wdata = d;
    tick();
    prog_we    = 1'b0;
  endtask

  task automatic go(input logic [CNT_W-1:0] n);
    exec_num = n;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Core model: retires each instruction one cycle after it is presented;
  // the PC walks words 0..3 unless held (branch-to-self).
  task automatic echo_step(input bit hold_pc);
    logic iv;
    iv = in_valid;
    tick();
    out_valid = iv;
    prog_we   = 1'b0;
    start     = 1'b0;
    if (iv && !hold_pc) core_pc = (core_pc + 4) % 16;
    inst_addr = core_pc;
  endtask

  task automatic run_echo(input bit hold_pc, input string name);
    int n = 0;
    while (!(done || fault) && n < 40) begin
      echo_step(hold_pc);
      n++;
    end
    check(name, 32'(n < 40), 32'd1);
  endtask

  initial begin : stim
    int n;
    int cyc;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_valid", 32'(in_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_code", 32'(fault_code), 0);
    check("rst_issued", 32'(issued_cnt), 0);
    check("rst_retired", 32'(retired_cnt), 0);
    rst_n = 1'b1;
    tick();

    load(9'd0, W0);
    load(9'd1, W1);
    load(9'd2, W2);
    load(9'd3, W3);

    // exec_num = 0 finishes at once
    go(16'd0);
    check("zero_done", 32'(done), 1);
    check("zero_busy", 32'(busy), 0);
    check("zero_issued", 32'(issued_cnt), 0);

    // Normal 4-instruction run
    core_pc = 0; inst_addr = 0;
    exp_q.push_back(W0); exp_q.push_back(W1); exp_q.push_back(W2); exp_q.push_back(W3);
    go(16'd4);
    check("t1_busy", 32'(busy), 1);
    check("t1_delay0", 32'(in_valid), 0);
    tick();
    check("t1_delay1", 32'(in_valid), 0);
    tick();
    check("t1_first_valid", 32'(in_valid), 1);
    run_echo(1'b0, "t1_budget");
    check("t1_done", 32'(done), 1);
    check("t1_fault", 32'(fault), 0);
    check("t1_busy_end", 32'(busy), 0);
    check("t1_issued", 32'(issued_cnt), 4);
    check("t1_retired", 32'(retired_cnt), 4);
    check("t1_sb_empty", 32'(exp_q.size()), 0);

    // Core never retires: latency fault after 10 in_valid cycles
    core_pc = 0; inst_addr = 0;
    repeat (10) exp_q.push_back(W0);
    go(16'd20);
    n = 0; cyc = 0;
    while (!fault && cyc < 30) begin
      tick();
      cyc++;
      if (in_valid) n++;
    end
    check("t2_cycles", cyc, 12);
    check("t2_valid_cycles", n, 10);
    check("t2_code", 32'(fault_code), 2);
    check("t2_in_valid", 32'(in_valid), 0);
    check("t2_issued", 32'(issued_cnt), 10);
    check("t2_retired", 32'(retired_cnt), 0);
    repeat (3) tick();
    check("t2_in_valid_later", 32'(in_valid), 0);
    check("t2_issued_frozen", 32'(issued_cnt), 10);
    check("t2_sb_empty", 32'(exp_q.size()), 0);

    // out_valid high 3 cycles then drops
    core_pc = 8; inst_addr = 8;
    repeat (5) exp_q.push_back(W2);
    go(16'd8);
    tick(); tick();
    check("t3_valid", 32'(in_valid), 1);
    tick();
    out_valid = 1'b1;
    repeat (3) tick();
    out_valid = 1'b0;
    check("t3_no_fault_yet", 32'(fault), 0);
    check("t3_retired_pre", 32'(retired_cnt), 3);
    tick();
    check("t3_fault", 32'(fault), 1);
    check("t3_code", 32'(fault_code), 3);
    check("t3_retired", 32'(retired_cnt), 3);
    check("t3_issued", 32'(issued_cnt), 5);
    check("t3_in_valid", 32'(in_valid), 0);
    check("t3_sb_empty", 32'(exp_q.size()), 0);

    // Misaligned PC
    inst_addr = 32'd6;
    exp_q.push_back(W1);
    go(16'd8);
    tick(); tick();
    check("t4a_valid", 32'(in_valid), 1);
    check("t4a_no_fault", 32'(fault), 0);
    tick();
    check("t4a_code", 32'(fault_code), 1);
    check("t4a_in_valid", 32'(in_valid), 0);
    check("t4a_issued", 32'(issued_cnt), 1);

    // PC beyond the ROM
    inst_addr = 32'd2048;
    exp_q.push_back(W0);
    go(16'd8);
    tick(); tick();
    check("t4b_valid", 32'(in_valid), 1);
    tick();
    check("t4b_fault", 32'(fault), 1);
    check("t4b_code", 32'(fault_code), 1);
    check("t4b_sb_empty", 32'(exp_q.size()), 0);

    // Reset during RUN after 5 issues, then rerun without reloading
    core_pc = 0; inst_addr = 0;
    exp_q.push_back(W0); exp_q.push_back(W1); exp_q.push_back(W2);
    exp_q.push_back(W3); exp_q.push_back(W0);
    go(16'd8);
    tick(); tick();
    repeat (5) echo_step(1'b0);
    check("t5_issued_pre", 32'(issued_cnt), 5);
    check("t5_valid_pre", 32'(in_valid), 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_in_valid", 32'(in_valid), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_issued", 32'(issued_cnt), 0);
    check("t5_rst_retired", 32'(retired_cnt), 0);
    out_valid = 1'b0; core_pc = 0; inst_addr = 0;
    tick();
    rst_n = 1'b1;
    check("t5_sb_empty_rst", 32'(exp_q.size()), 0);
    exp_q.push_back(W0); exp_q.push_back(W1); exp_q.push_back(W2); exp_q.push_back(W3);
    go(16'd4);
    tick(); tick();
    run_echo(1'b0, "t5_budget");
    check("t5_done", 32'(done), 1);
    check("t5_retired", 32'(retired_cnt), 4);
    check("t5_sb_empty", 32'(exp_q.size()), 0);

    // Write and start during RUN are ignored; out_valid in DONE faults
    core_pc = 0; inst_addr = 0;
    repeat (4) exp_q.push_back(W0);
    go(16'd4);
    tick(); tick();
    prog_we = 1'b1; prog_addr = 9'd0; prog_wdata = 32'hDEADBEEF;
    exec_num = 16'd1; start = 1'b1;
    run_echo(1'b1, "t6_budget");
    check("t6_done", 32'(done), 1);
    check("t6_issued", 32'(issued_cnt), 4);
    check("t6_retired", 32'(retired_cnt), 4);
    check("t6_sb_empty", 32'(exp_q.size()), 0);
    out_valid = 1'b1;
    tick();
    out_valid = 1'b0;
    check("t6_fault", 32'(fault), 1);
    check("t6_done_cleared", 32'(done), 0);
    check("t6_code", 32'(fault_code), 3);
    check("t6_retired_frozen", 32'(retired_cnt), 4);

    // Writes are honoured in FAULT
    load(9'd0, 32'h00000013);
    core_pc = 0; inst_addr = 0;
    exp_q.push_back(32'h00000013);
    go(16'd1);
    tick(); tick();
    run_echo(1'b1, "t7_budget");
    check("t7_done", 32'(done), 1);
    check("t7_issued", 32'(issued_cnt), 1);
    check("t7_sb_empty", 32'(exp_q.size()), 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
